// File: rtl/sdram_burst_arbiter.sv
// sdram_burst_arbiter: N-channel fixed-length burst scheduler in front of the SDRAM controller.
// Optional SDRAM_ARB_READ_PRIORITY_EN: read channels beat write channels, each group with its own round robin.
module sdram_burst_arbiter #(
    parameter int NUM_CH = 4,
    parameter logic [NUM_CH-1:0] CH_IS_READ = 4'b0001,
    parameter int BURST_LEN = 8,
    parameter int ADDR_WIDTH = 22,
    parameter int DATA_WIDTH = 16,
    parameter int LEVEL_WIDTH = 5
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic [NUM_CH-1:0]                     ch_enable,
    input  logic [NUM_CH-1:0]                     ch_restart,
    input  logic [NUM_CH-1:0][ADDR_WIDTH-1:0]     ch_region_base,
    input  logic [NUM_CH-1:0][ADDR_WIDTH-1:0]     ch_region_end,
    input  logic [NUM_CH-1:0][LEVEL_WIDTH-1:0]    ch_level,
    input  logic [NUM_CH-1:0][DATA_WIDTH-1:0]     ch_wr_data,
    output logic [NUM_CH-1:0]                     ch_wr_ack,
    output logic [DATA_WIDTH-1:0]                 ch_rd_data,
    output logic [NUM_CH-1:0]                     ch_rd_valid,
    output logic [NUM_CH-1:0]                     ch_wrap,
    output logic [1:0]                            command,
    output logic [ADDR_WIDTH-1:0]                 data_address,
    output logic [DATA_WIDTH-1:0]                 data_write,
    input  logic [DATA_WIDTH-1:0]                 data_read,
    input  logic                                  data_read_valid,
    input  logic                                  data_write_done
);
    localparam int IW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    localparam int BW = BURST_LEN > 1 ? $clog2(BURST_LEN) : 1;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BURST = 1'b1;
    localparam logic [IW-1:0] LAST_CH = IW'(NUM_CH - 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);
    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(BURST_LEN);

    logic [0:0] state;
    logic [IW-1:0] g;
    logic [IW-1:0] g_next;
    logic [IW-1:0] pick;
    logic [BW-1:0] beat_cnt;
    logic [NUM_CH-1:0][ADDR_WIDTH-1:0] offset;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] eligible;
    logic [NUM_CH-1:0] sel;
    logic [ADDR_WIDTH-1:0] next_off;
    logic busy, rd, beat, done, hit, found;

    // First set bit of m at or after position p, wrapping; MSB of the result flags a hit.
    function automatic logic [IW:0] scan(input logic [NUM_CH-1:0] m, input logic [IW-1:0] p);
        logic [IW:0] r;
        int j;
        r = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            j = (int'(p) + k) % NUM_CH;
            if (m[j]) r = {1'b1, IW'(j)};
        end
        return r;
    endfunction

    always_comb
        for (int i = 0; i < NUM_CH; i++)
            eligible[i] = ch_enable[i] && (32'(ch_level[i]) >= BURST_LEN);

`ifdef SDRAM_ARB_READ_PRIORITY_EN
    logic [IW-1:0] rr_rd, rr_wr;
    assign {found, pick} = |(eligible & CH_IS_READ) ? scan(eligible & CH_IS_READ, rr_rd)
                                                    : scan(eligible & ~CH_IS_READ, rr_wr);
`else
    logic [IW-1:0] rr;
    assign {found, pick} = scan(eligible, rr);
`endif

    assign busy = state == BURST;
    assign rd = CH_IS_READ[g];
    assign beat = busy && (rd ? data_read_valid : data_write_done);
    assign done = beat && beat_cnt == LAST_BEAT;
    assign next_off = offset[g] + STEP;
    assign hit = ch_region_base[g] + next_off >= ch_region_end[g];
    assign g_next = g == LAST_CH ? '0 : g + 1'b1;
    assign sel = NUM_CH'(1) << g;
    assign command = busy ? (rd ? 2'd2 : 2'd1) : 2'd0;
    assign data_address = ch_region_base[g] + offset[g];
    assign data_write = ch_wr_data[g];
    assign ch_rd_data = data_read;
    assign ch_wr_ack = busy && !rd && data_write_done ? sel : '0;
    assign ch_rd_valid = busy && rd && data_read_valid ? sel : '0;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state <= IDLE;
            g <= '0;
            beat_cnt <= '0;
            offset <= '0;
            pending <= '0;
            ch_wrap <= '0;
`ifdef SDRAM_ARB_READ_PRIORITY_EN
            rr_rd <= '0;
            rr_wr <= '0;
`else
            rr <= '0;
`endif
        end else begin
            ch_wrap <= '0;
            if (!busy) begin
                beat_cnt <= '0;
                if (found) begin
                    state <= BURST;
                    g <= pick;
                end
            end else if (beat) begin
                beat_cnt <= beat_cnt + 1'b1;
                if (done) begin
                    state <= IDLE;
`ifdef SDRAM_ARB_READ_PRIORITY_EN
                    if (rd) rr_rd <= g_next;
                    else rr_wr <= g_next;
`else
                    rr <= g_next;
`endif
                end
            end
            // A restart during the granted channel's burst is deferred so the address stays stable.
            for (int i = 0; i < NUM_CH; i++) begin
                if (busy && g == IW'(i)) begin
                    if (done) begin
                        pending[i] <= 1'b0;
                        if (pending[i] || ch_restart[i]) offset[i] <= '0;
                        else if (hit) begin
                            offset[i] <= '0;
                            ch_wrap[i] <= 1'b1;
                        end else offset[i] <= next_off;
                    end else if (ch_restart[i]) pending[i] <= 1'b1;
                end else if (ch_restart[i]) offset[i] <= '0;
            end
        end
endmodule

// File: tb/tb_sdram_burst_arbiter.sv
// tb_sdram_burst_arbiter: two-channel bench (ch0 read, ch1 write) with a beat/wrap scoreboard.
module tb_sdram_burst_arbiter;
    typedef struct {
        logic [1:0]  sel;
        logic        rd;
        logic [21:0] addr;
        logic [15:0] data;
    } beat_t;

    logic clk = 0;
    logic reset_n = 0;
    logic [1:0] ch_enable = 2'b11;
    logic [1:0] ch_restart = '0;
    logic [1:0][21:0] ch_region_base;
    logic [1:0][21:0] ch_region_end;
    logic [1:0][4:0] ch_level = '0;
    logic [1:0][15:0] ch_wr_data;
    logic [1:0] ch_wr_ack, ch_rd_valid, ch_wrap;
    logic [15:0] ch_rd_data, data_write;
    logic [15:0] data_read = '0;
    logic [1:0] command;
    logic [21:0] data_address;
    logic data_read_valid = 0;
    logic data_write_done = 0;

    int checks = 0;
    int failures = 0;
    int nb = 0;
    beat_t exp_q[$];
    logic [1:0] wrap_q[$];
    beat_t e;
    logic [1:0] w;
    logic [15:0] act_data;

    int t2_ch[5];
    logic [21:0] t2_addr[5];
    bit t2_wrap[5];

    sdram_burst_arbiter #(
        .NUM_CH(2), .CH_IS_READ(2'b01), .BURST_LEN(8),
        .ADDR_WIDTH(22), .DATA_WIDTH(16), .LEVEL_WIDTH(5)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ch_enable(ch_enable), .ch_restart(ch_restart),
        .ch_region_base(ch_region_base), .ch_region_end(ch_region_end), .ch_level(ch_level),
        .ch_wr_data(ch_wr_data), .ch_wr_ack(ch_wr_ack), .ch_rd_data(ch_rd_data),
        .ch_rd_valid(ch_rd_valid), .ch_wrap(ch_wrap), .command(command),
        .data_address(data_address), .data_write(data_write), .data_read(data_read),
        .data_read_valid(data_read_valid), .data_write_done(data_write_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Monitor: every beat or wrap pulse the DUT presents is checked against the scoreboard.
    always @(negedge clk) begin
        if ((ch_wr_ack | ch_rd_valid) != 2'b00) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL beat_unexpected: ack=%b valid=%b addr=%h, required no beat", ch_wr_ack, ch_rd_valid, data_address);
            end else begin
                e = exp_q.pop_front();
                act_data = e.rd ? ch_rd_data : data_write;
                if (ch_wr_ack != (e.rd ? 2'b00 : e.sel) || ch_rd_valid != (e.rd ? e.sel : 2'b00) ||
                    command != (e.rd ? 2'd2 : 2'd1) || data_address != e.addr || act_data != e.data) begin
                    failures++;
                    $display("FAIL beat: ack=%b valid=%b cmd=%0d addr=%h data=%h, required sel=%b rd=%b addr=%h data=%h",
                             ch_wr_ack, ch_rd_valid, command, data_address, act_data, e.sel, e.rd, e.addr, e.data);
                end
            end
        end
        if (ch_wrap != 2'b00) begin
            checks++;
            if (wrap_q.size() == 0) begin
                failures++;
                $display("FAIL wrap_unexpected: ch_wrap=%b, required 00", ch_wrap);
            end else begin
                w = wrap_q.pop_front();
                if (ch_wrap != w) begin
                    failures++;
                    $display("FAIL wrap: ch_wrap=%b, required %b", ch_wrap, w);
                end
            end
        end
    end

    // Acts as the SDRAM controller for one burst of channel ch (read when ch==0).
    task automatic run_burst(input int ch, input logic [21:0] addr, input bit wrap,
                             input int rst_beat, input int abort_beat);
        int n = 0;
        logic rd = (ch == 0);
        logic [1:0] s = (ch == 0) ? 2'b01 : 2'b10;
        while (command == 2'd0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(command != 2'd0, "grant_timeout", 32'(command), 32'(rd ? 2 : 1));
        if (command == 2'd0) return;
        for (int b = 0; b < 8; b++) begin
            @(posedge clk);
            #1;
            ch_restart = '0;
            if (rd) begin
                data_read_valid = 1;
                data_read = 16'h5000 + 16'(nb);
            end else begin
                data_write_done = 1;
                ch_wr_data[ch] = 16'hA000 + 16'(nb);
            end
            nb++;
            if (b == abort_beat) begin
                reset_n = 0;
                @(negedge clk);
                chk(command == 2'd0 && ch_rd_valid == 2'b00, "reset_mid_burst",
                    {14'd0, command, ch_rd_valid}, 32'd0);
                @(posedge clk);
                #1;
                data_read_valid = 0;
                data_write_done = 0;
                @(posedge clk);
                #1;
                reset_n = 1;
                return;
            end
            exp_q.push_back('{s, rd, addr, rd ? data_read : ch_wr_data[ch]});
            if (b == rst_beat) ch_restart[ch] = 1;
        end
        @(posedge clk);
        #1;
        data_read_valid = 0;
        data_write_done = 0;
        ch_restart = '0;
        if (wrap) wrap_q.push_back(s);
    endtask

    initial begin
        ch_region_base[0] = 22'h100;
        ch_region_end[0] = 22'h110;
        ch_region_base[1] = 22'h2000;
        ch_region_end[1] = 22'h2018;
        ch_wr_data[0] = 16'hDEAD;
        ch_wr_data[1] = 16'h0000;
`ifdef SDRAM_ARB_READ_PRIORITY_EN
        t2_ch = '{0, 0, 0, 0, 0};
        t2_addr = '{22'h100, 22'h108, 22'h100, 22'h108, 22'h100};
        t2_wrap = '{0, 1, 0, 1, 0};
`else
        t2_ch = '{0, 1, 0, 1, 0};
        t2_addr = '{22'h100, 22'h2000, 22'h108, 22'h2008, 22'h100};
        t2_wrap = '{0, 0, 1, 0, 0};
`endif
        repeat (2) @(negedge clk);
        chk(command == 2'd0 && ch_wr_ack == 2'b00 && ch_rd_valid == 2'b00 && ch_wrap == 2'b00,
            "reset_outputs", {24'd0, command, ch_wr_ack, ch_rd_valid, ch_wrap}, 32'd0);
        chk(data_address == 22'h100, "reset_address", 32'(data_address), 32'h100);
        @(posedge clk);
        #1;
        reset_n = 1;
        ch_level[1] = 5'd7;
        repeat (4) begin
            @(negedge clk);
            chk(command == 2'd0, "level7_no_grant", 32'(command), 32'd0);
        end
        @(posedge clk);
        #1;
        ch_level[1] = 5'd8;
        @(negedge clk);
        chk(command == 2'd0, "grant_early", 32'(command), 32'd0);
        @(negedge clk);
        chk(command == 2'd1, "grant_edge2", 32'(command), 32'd1);
        chk(data_address == 22'h2000, "grant_addr", 32'(data_address), 32'h2000);
        run_burst(1, 22'h2000, 0, -1, -1);
        run_burst(1, 22'h2008, 0, -1, -1);
        run_burst(1, 22'h2010, 1, -1, -1);
        ch_level[0] = 5'd8;
        for (int i = 0; i < 5; i++) run_burst(t2_ch[i], t2_addr[i], t2_wrap[i], -1, -1);
        ch_level[0] = 5'd0;
        ch_restart[1] = 1;
        @(posedge clk);
        #1;
        ch_restart = '0;
        run_burst(1, 22'h2000, 0, 3, -1);
        run_burst(1, 22'h2000, 0, -1, -1);
        run_burst(1, 22'h2008, 0, -1, -1);
        ch_level[1] = 5'd0;
        ch_level[0] = 5'd8;
        run_burst(0, 22'h108, 0, -1, 5);
        run_burst(0, 22'h100, 0, -1, -1);
        ch_level = '0;
        repeat (4) @(negedge clk);
        chk(exp_q.size() == 0, "beat_queue_drained", 32'(exp_q.size()), 32'd0);
        chk(wrap_q.size() == 0, "wrap_queue_drained", 32'(wrap_q.size()), 32'd0);
        chk(command == 2'd0, "final_idle", 32'(command), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
